// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding memory request feeding a 2-entry
// {pc, instr} buffer toward decode, with redirect/kill handling.
module fetch #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [ADDR_W-1:0]     PC_INC   = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               stall,
  input  logic               i_br_taken,
  input  logic [ADDR_W-1:0]  i_br_target,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_KILL
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   f_pc, f_pc_nx;
  logic [ADDR_W-1:0]   req_addr, req_addr_nx;
  logic [1:0]          count, count_nx;
  logic                rd_ptr, wr_ptr;
  logic [ADDR_W-1:0]   buf_pc    [2];
  logic [INSTR_W-1:0]  buf_instr [2];
  logic                push, pop, room;

  // Buffer bookkeeping; a redirect flushes and wins over push/pop
  always_comb begin
    pop  = !stall && (count != 2'd0) && !i_br_taken;
    push = (state == S_FETCH) && i_imem_ack && !i_br_taken;
    if (i_br_taken) count_nx = '0;
    else            count_nx = count + {1'b0, push} - {1'b0, pop};
    room = (count_nx < 2'd2);
  end

  always_comb begin
    state_nx    = state;
    f_pc_nx     = f_pc;
    req_addr_nx = req_addr;
    unique case (state)
      S_IDLE: begin
        if (i_br_taken) begin
          f_pc_nx     = i_br_target;
          req_addr_nx = i_br_target;
          state_nx    = S_FETCH;
        end else if (room) begin
          req_addr_nx = f_pc;
          state_nx    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_br_taken && i_imem_ack) begin
          f_pc_nx     = i_br_target;
          req_addr_nx = i_br_target;
        end else if (i_br_taken) begin
          f_pc_nx  = i_br_target;
          state_nx = S_KILL;
        end else if (i_imem_ack) begin
          f_pc_nx = req_addr + PC_INC;
          if (room) req_addr_nx = req_addr + PC_INC;
          else      state_nx    = S_IDLE;
        end
      end
      S_KILL: begin
        // The stale request must drain before a new address can be issued
        if (i_imem_ack) begin
          f_pc_nx     = i_br_taken ? i_br_target : f_pc;
          req_addr_nx = i_br_taken ? i_br_target : f_pc;
          state_nx    = S_FETCH;
        end else if (i_br_taken) begin
          f_pc_nx = i_br_target;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      f_pc     <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state    <= state_nx;
      f_pc     <= f_pc_nx;
      req_addr <= req_addr_nx;
      count    <= count_nx;
      if (i_br_taken) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= req_addr;
      buf_instr[wr_ptr] <= i_imem_data;
    end
  end

  always_comb begin
    o_imem_req  = ((state == S_FETCH) || (state == S_KILL)) && !clr;
    o_imem_addr = req_addr;
    o_valid     = (count != 2'd0) && !i_br_taken && !clr;
    o_pc        = o_valid ? buf_pc[rd_ptr]    : '0;
    o_instr     = o_valid ? buf_instr[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: randomized memory latency/stall/redirect against an
// architectural instruction-stream model, plus directed scenarios.
module tb_fetch;

  logic        clk = 1'b0;
  logic        clr, stall, br, ack;
  logic [31:0] tgt, data;
  logic        req, valid;
  logic [31:0] addr, pc, instr;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr, w_data;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_INC(32'd4)) dut (
    .clk(clk), .clr(clr), .stall(stall), .i_br_taken(br), .i_br_target(tgt),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_data(data),
    .o_pc(pc), .o_instr(instr), .o_valid(valid)
  );

  assign w_data = mem(w_addr);

  fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8), .PC_INC(32'd4)) u_wrap (
    .clk(clk), .clr(clr), .stall(1'b0), .i_br_taken(1'b0), .i_br_target(32'h0),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(w_req), .i_imem_data(w_data),
    .o_pc(w_pc), .o_instr(w_instr), .o_valid(w_valid)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] wexp   = 32'hFFFF_FFF8;
  bit          pending = 0;
  int          lat_left = 0;
  int          fixed_lat = 0;
  logic [31:0] req_a = 32'h0;
  bit          prev_hold = 0;
  logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic step();
    if (clr) begin
      ack  = 1'b0;
      data = $urandom;
    end else if (req) begin
      if (!pending) begin
        pending  = 1;
        lat_left = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
        req_a    = addr;
      end else begin
        chk("addr_stable", addr, req_a);
      end
      ack  = (lat_left == 0);
      data = ack ? mem(addr) : $urandom;
    end else begin
      ack  = 1'b0;
      data = $urandom;
    end
    #1;
    if (clr) begin
      chk("rst_req",   32'(req),   32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_pc",    pc,         32'h0);
      chk("rst_instr", instr,      32'h0);
      chk("rst_wvalid", 32'(w_valid), 32'h0);
      prev_hold = 0;
      exp_pc    = 32'h0;
      wexp      = 32'hFFFF_FFF8;
    end else begin
      if (prev_hold && !br) begin
        chk("freeze_valid", 32'(valid), 32'h1);
        chk("freeze_pc",    pc,         prev_pc);
        chk("freeze_instr", instr,      prev_instr);
      end
      if (br) chk("br_bubble", 32'(valid), 32'h0);
      if (!valid) begin
        chk("bubble_pc",    pc,    32'h0);
        chk("bubble_instr", instr, 32'h0);
      end
      if (valid && !stall && !br) begin
        chk("stream_pc",    pc,    exp_pc);
        chk("stream_instr", instr, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      prev_hold  = valid && stall && !br;
      prev_pc    = pc;
      prev_instr = instr;
      if (br) exp_pc = tgt;
      if (w_valid) begin
        chk("wrap_pc",    w_pc,    wexp);
        chk("wrap_instr", w_instr, mem(wexp));
        wexp = wexp + 32'd4;
      end
    end
    @(posedge clk);
    if (clr)           pending = 0;
    else if (ack)      pending = 0;
    else if (pending)  lat_left--;
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; stall = 1'b0; br = 1'b0;
    repeat (2) step();
    clr = 1'b0;
  endtask

  initial begin
    bit found;
    clr = 1'b1; stall = 1'b0; br = 1'b0; tgt = 32'h0; ack = 1'b0; data = 32'h0;
    @(posedge clk); #1;
    repeat (3) step();

    // Streaming from reset with zero-latency memory
    clr = 1'b0;
    step();
    chk("first_req",  32'(req), 32'h1);
    chk("first_addr", addr,     32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("s_valid",  32'(valid), 32'h1);
      chk("s_pc",     pc,         32'(4 * i));
      chk("s_wrappc", w_pc,       32'hFFFF_FFF8 + 32'(4 * i));
      step();
    end

    // Backpressure: buffer fills, requests stop, then resumes gap-free
    stall = 1'b1;
    repeat (6) step();
    chk("bp_idle",  32'(req),   32'h0);
    chk("bp_valid", 32'(valid), 32'h1);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_nogap", 32'(valid), 32'h1);
      step();
    end

    // Redirect while a slow request to 0x10 is pending
    fixed_lat = 3;
    do_reset();
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (req && addr == 32'h10 && !pending) found = 1;
      else step();
    end
    chk("kill_found", 32'(found), 32'h1);
    step();
    br = 1'b1; tgt = 32'h100;
    step();
    br = 1'b0;
    chk("kill_req",  32'(req), 32'h1);
    chk("kill_addr", addr,     32'h10);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (req && addr != 32'h10) found = 1;
      else step();
    end
    chk("kill_next_found", 32'(found), 32'h1);
    chk("kill_next_addr",  addr,       32'h100);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (valid) found = 1;
      else step();
    end
    chk("kill_first_valid", 32'(found), 32'h1);
    chk("kill_first_pc",    pc,         32'h100);

    // Redirect coincident with the ack for 0x8
    fixed_lat = 0;
    do_reset();
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (req && addr == 32'h8) found = 1;
      else step();
    end
    chk("coinc_found", 32'(found), 32'h1);
    br = 1'b1; tgt = 32'h40;
    step();
    br = 1'b0;
    chk("coinc_empty", 32'(valid), 32'h0);
    chk("coinc_req",   32'(req),   32'h1);
    chk("coinc_addr",  addr,       32'h40);
    step();

    // Randomized traffic
    fixed_lat = -1;
    for (int n = 0; n < 1500; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 19) == 0);
      tgt   = $urandom & 32'hFFFF_FFFC;
      step();
    end
    br = 1'b0; stall = 1'b0;

    // Reset in the middle of buffered / outstanding work
    fixed_lat = 3;
    stall = 1'b1;
    repeat (8) step();
    chk("midclr_full", 32'(valid), 32'h1);
    clr = 1'b1;
    step();
    step();
    clr = 1'b0; stall = 1'b0;
    step();
    chk("restart_req",  32'(req), 32'h1);
    chk("restart_addr", addr,     32'h0);
    repeat (12) step();
    chk("restart_progress", 32'(exp_pc != 32'h0), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
